// File: rtl/dvp_frame_gen.sv
// DVP camera-side frame generator.
// Produces cam_vsync/cam_href/cam_data (RGB565 split MSB-first) on cam_pclk.
// Pixels come from a BRAM read port or from a built-in test pattern.
// The internal timing counters run one cycle ahead of the registered outputs.
// BRAM reads are issued two output cycles before the first byte of the pixel they fetch.
module dvp_frame_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int ADDR_W      = 19
) (
    input  logic              cam_pclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        pattern_sel,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic              cam_vsync,
    output logic              cam_href,
    output logic [7:0]        cam_data,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    localparam int L         = 2 * H_ACTIVE + H_BLANK;
    localparam int H_W       = (L > 2) ? $clog2(L) : 2;
    localparam int MAX_A     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_B     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int V_W       = (MAX_LINES > 1) ? $clog2(MAX_LINES + 1) : 1;
    localparam int BAR_W     = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int BAR_CW    = $clog2(BAR_W + 1);

    localparam logic [H_W-1:0]    H_LAST      = H_W'(L - 1);
    localparam logic [H_W-1:0]    H_PREFETCH  = H_W'(L - 2);
    localparam logic [H_W-1:0]    H_PIX_END   = H_W'(2 * H_ACTIVE);
    localparam logic [H_W-1:0]    H_FETCH_END = H_W'(2 * H_ACTIVE - 2);
    localparam logic [V_W-1:0]    VS_LAST     = V_W'(VSYNC_LINES - 1);
    localparam logic [V_W-1:0]    VB_LAST     = V_W'(V_BACK - 1);
    localparam logic [V_W-1:0]    VA_LAST     = V_W'(V_ACTIVE - 1);
    localparam logic [V_W-1:0]    VF_LAST     = V_W'(V_FRONT - 1);
    localparam logic [BAR_CW-1:0] BAR_LAST    = BAR_CW'(BAR_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t            state_q, state_d;
    logic [H_W-1:0]    h_cnt, h_d;
    logic [V_W-1:0]    v_cnt, v_d;
    logic [V_W-1:0]    last_line;
    logic              frame_end;
    logic              done_p;
    logic [1:0]        pat_q;
    logic [ADDR_W-1:0] addr_cnt;
    logic [15:0]       pix_cnt;
    logic [7:0]        lo_byte;
    logic [BAR_CW-1:0] bar_col;
    logic [2:0]        bar_idx;

    logic              in_pix;
    logic              pix_first;
    logic              next_line_active;
    logic              fetch;
    logic              frame_sample;
    logic [15:0]       pix_val;

    // RGB565 colour of each of the eight vertical bars, left to right.
    function automatic logic [15:0] bar_colour(input logic [2:0] b);
        case (b)
            3'd0:    bar_colour = 16'hFFFF;
            3'd1:    bar_colour = 16'hFFE0;
            3'd2:    bar_colour = 16'h07FF;
            3'd3:    bar_colour = 16'h07E0;
            3'd4:    bar_colour = 16'hF81F;
            3'd5:    bar_colour = 16'hF800;
            3'd6:    bar_colour = 16'h001F;
            default: bar_colour = 16'h0000;
        endcase
    endfunction

    // Frame FSM and line/column counters.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            state_q <= state_d;
            h_cnt   <= h_d;
            v_cnt   <= v_d;
        end
    end

    // Next state: counters advance per cycle, phases advance per completed line group.
    always_comb begin
        state_d   = state_q;
        h_d       = h_cnt;
        v_d       = v_cnt;
        frame_end = 1'b0;
        case (state_q)
            S_VSYNC:  last_line = VS_LAST;
            S_VBACK:  last_line = VB_LAST;
            S_ACTIVE: last_line = VA_LAST;
            default:  last_line = VF_LAST;
        endcase
        if (state_q == S_IDLE) begin
            h_d = '0;
            v_d = '0;
            if (enable) state_d = S_VSYNC;
        end else if (h_cnt == H_LAST) begin
            h_d = '0;
            if (v_cnt == last_line) begin
                v_d = '0;
                case (state_q)
                    S_VSYNC:  state_d = S_VBACK;
                    S_VBACK:  state_d = S_ACTIVE;
                    S_ACTIVE: state_d = S_VFRONT;
                    default: begin
                        frame_end = 1'b1;
                        state_d   = enable ? S_VSYNC : S_IDLE;
                    end
                endcase
            end else begin
                v_d = v_cnt + V_W'(1);
            end
        end else begin
            h_d = h_cnt + H_W'(1);
        end
    end

    // Decode of the current counter position into pixel and fetch events.
    always_comb begin
        in_pix           = (state_q == S_ACTIVE) && (h_cnt < H_PIX_END);
        pix_first        = in_pix && !h_cnt[0];
        next_line_active = ((state_q == S_ACTIVE) && (v_cnt != VA_LAST)) ||
                           ((state_q == S_VBACK) && (v_cnt == VB_LAST));
        fetch            = (pat_q == 2'd0) &&
                           ((pix_first && (h_cnt < H_FETCH_END)) ||
                            ((h_cnt == H_PREFETCH) && next_line_active));
        frame_sample     = (state_q == S_VSYNC) && (v_cnt == '0) && (h_cnt == H_W'(1));
        case (pat_q)
            2'd0:    pix_val = rd_data;
            2'd1:    pix_val = bar_colour(bar_idx);
            2'd2:    pix_val = pix_cnt;
            default: pix_val = 16'h0000;
        endcase
    end

    // Registered sync outputs, BRAM read strobe/address and completed-frame count.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            cam_vsync <= 1'b0;
            cam_href  <= 1'b0;
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            addr_cnt  <= '0;
            pat_q     <= 2'd0;
            done_p    <= 1'b0;
            frame_cnt <= 16'h0000;
        end else begin
            cam_vsync <= (state_q == S_VSYNC);
            cam_href  <= in_pix;
            busy      <= (state_q != S_IDLE);
            rd_en     <= fetch;
            if (frame_sample) begin
                pat_q    <= pattern_sel;
                rd_addr  <= '0;
                addr_cnt <= '0;
            end else if (fetch) begin
                rd_addr  <= addr_cnt;
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end
            done_p <= frame_end;
            if (done_p) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Byte serialiser plus pattern generators (pixel counter and bar position).
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            cam_data <= 8'h00;
            lo_byte  <= 8'h00;
            pix_cnt  <= 16'h0000;
            bar_col  <= '0;
            bar_idx  <= 3'd0;
        end else begin
            if (!in_pix) begin
                cam_data <= 8'h00;
            end else if (!h_cnt[0]) begin
                cam_data <= pix_val[15:8];
                lo_byte  <= pix_val[7:0];
            end else begin
                cam_data <= lo_byte;
            end

            if (frame_sample) begin
                pix_cnt <= 16'h0000;
            end else if (pix_first) begin
                pix_cnt <= pix_cnt + 16'd1;
            end

            if (!in_pix) begin
                bar_col <= '0;
                bar_idx <= 3'd0;
            end else if (pix_first) begin
                if (bar_col == BAR_LAST) begin
                    bar_col <= '0;
                    if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_col <= bar_col + BAR_CW'(1);
                end
            end
        end
    end

endmodule
